// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the barrel shifter: operating-mode encodings.
package barrel_shifter_pkg;

   localparam logic [1:0] MODE_LOGICAL  = 2'b00;
   localparam logic [1:0] MODE_ARITH    = 2'b01;
   localparam logic [1:0] MODE_ROTATE   = 2'b10;
   localparam logic [1:0] MODE_RESERVED = 2'b11;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One stage of the logarithmic shift network: conditionally moves data by
// STAGE_SHIFT positions, filling vacated bits with the fill bit or the rotated-out bits.
module barrel_shifter_stage
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int STAGE_SHIFT = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  logic             dir,
   input  logic             fill,
   input  logic             rotate,
   output logic [WIDTH-1:0] result
);

   logic [STAGE_SHIFT-1:0] left_in;
   logic [STAGE_SHIFT-1:0] right_in;

   always_comb begin
      left_in  = rotate ? data[WIDTH-1 -: STAGE_SHIFT] : {STAGE_SHIFT{fill}};
      right_in = rotate ? data[STAGE_SHIFT-1:0]        : {STAGE_SHIFT{fill}};
      if (!enable) begin
         result = data;
      end else if (dir) begin
         result = {right_in, data[WIDTH-1:STAGE_SHIFT]};
      end else begin
         result = {data[WIDTH-1-STAGE_SHIFT:0], left_in};
      end
   end

endmodule

// File: rtl/barrel_shifter.sv
// Registered barrel shifter: logical/arithmetic shift and rotate, either
// direction, one-cycle latency, a new operation every cycle.
module barrel_shifter
   import barrel_shifter_pkg::*;
#(
   parameter  int WIDTH   = 8,
   localparam int SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               dir,
   input  logic [1:0]         mode,
   output logic [WIDTH-1:0]   data_out,
   output logic               out_valid
);

   logic [WIDTH-1:0] stage_data [SHIFT_W+1];
   logic             fill;
   logic             rotate;

   // Sign fill only for arithmetic right; arithmetic left behaves as logical.
   always_comb begin
      rotate = (mode == MODE_ROTATE);
      fill   = (mode == MODE_ARITH) && dir && data_in[WIDTH-1];
   end

   assign stage_data[0] = data_in;

   for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
      barrel_shifter_stage #(
         .WIDTH       (WIDTH),
         .STAGE_SHIFT (2 ** k)
      ) u_stage (
         .data   (stage_data[k]),
         .enable (shift[k]),
         .dir    (dir),
         .fill   (fill),
         .rotate (rotate),
         .result (stage_data[k+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out <= stage_data[SHIFT_W];
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter (WIDTH=8): directed vectors push expected
// results; a monitor pops and compares whenever out_valid is seen.
module tb_barrel_shifter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] data_in;
   logic [2:0] shift;
   logic       dir;
   logic [1:0] mode;
   logic [7:0] data_out;
   logic       out_valid;

   int errors = 0;
   int checks = 0;
   int pushed = 0;
   int popped = 0;

   logic [7:0] sb [$];
   string      names [$];
   logic [7:0] hold_val = 8'h00;

   always #5 clk = ~clk;

   barrel_shifter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .shift     (shift),
      .dir       (dir),
      .mode      (mode),
      .data_out  (data_out),
      .out_valid (out_valid)
   );

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   task automatic apply(string name, logic [7:0] d, logic [2:0] s, logic dr,
                        logic [1:0] m, logic [7:0] exp);
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = d;
      shift    = s;
      dir      = dr;
      mode     = m;
      sb.push_back(exp);
      names.push_back(name);
      pushed++;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         data_in  = 8'h5A;
         shift    = 3'd5;
         dir      = 1'b1;
         mode     = 2'b10;
      end
   endtask

   // Monitor: output sampled on the falling edge, away from the capture edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               logic [7:0] exp;
               string      nm;
               exp = sb.pop_front();
               nm  = names.pop_front();
               popped++;
               check(nm, 32'(data_out), 32'(exp));
               hold_val = exp;
            end
         end else begin
            check("hold_when_idle", 32'(data_out), 32'(hold_val));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = 8'hFF;
      shift    = 3'd0;
      dir      = 1'b0;
      mode     = 2'b00;
      #13;
      check("reset_data_out", 32'(data_out), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      apply("lsl_1",      8'b11110000, 3'd1, 1'b0, 2'b00, 8'b11100000);
      apply("lsl_3",      8'b11110000, 3'd3, 1'b0, 2'b00, 8'b10000000);
      apply("lsr_4",      8'b11110000, 3'd4, 1'b1, 2'b00, 8'b00001111);
      apply("lsr_7",      8'b11110000, 3'd7, 1'b1, 2'b00, 8'b00000001);
      apply("lsr_2",      8'b00011111, 3'd2, 1'b1, 2'b00, 8'b00000111);
      idle(2);
      apply("asr_neg_3",  8'b10101010, 3'd3, 1'b1, 2'b01, 8'b11110101);
      apply("asr_pos_3",  8'b01010101, 3'd3, 1'b1, 2'b01, 8'b00001010);
      apply("asr_neg_7",  8'b10000000, 3'd7, 1'b1, 2'b01, 8'b11111111);
      apply("asl_1",      8'b10101010, 3'd1, 1'b0, 2'b01, 8'b01010100);
      apply("rol_1",      8'b11001100, 3'd1, 1'b0, 2'b10, 8'b10011001);
      apply("ror_3",      8'b11001100, 3'd3, 1'b1, 2'b10, 8'b10011001);
      apply("rol_7",      8'b11001100, 3'd7, 1'b0, 2'b10, 8'b01100110);
      apply("lsl_max",    8'b10000001, 3'd7, 1'b0, 2'b00, 8'b10000000);
      apply("rsvd_r7",    8'b10000000, 3'd7, 1'b1, 2'b11, 8'b00000001);
      apply("rsvd_l7",    8'b11111111, 3'd7, 1'b0, 2'b11, 8'b10000000);
      idle(1);
      apply("zero_lsl",   8'b11001100, 3'd0, 1'b0, 2'b00, 8'b11001100);
      apply("zero_asr",   8'b11001100, 3'd0, 1'b1, 2'b01, 8'b11001100);
      apply("zero_ror",   8'b11001100, 3'd0, 1'b1, 2'b10, 8'b11001100);
      apply("zero_rsvd",  8'b11001100, 3'd0, 1'b0, 2'b11, 8'b11001100);
      idle(3);

      for (int i = 0; i < 8; i++) begin
         apply($sformatf("b2b_rol_%0d", i), 8'b00000001, 3'(i), 1'b0, 2'b10,
               8'(1 << i));
      end
      idle(2);

      // Reset pulsed between edges while a fresh result is on the output.
      apply("pre_reset",  8'b00000011, 3'd2, 1'b0, 2'b00, 8'b00001100);
      apply("inflight",   8'b11111111, 3'd1, 1'b1, 2'b00, 8'b01111111);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("async_rst_data_out", 32'(data_out), 32'd0);
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("discarded_count", 32'(sb.size()), 32'd1);
      sb.delete();
      names.delete();
      pushed   = pushed - 1;
      hold_val = 8'h00;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      apply("post_reset", 8'b00110011, 3'd2, 1'b1, 2'b10, 8'b11001100);
      idle(3);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("results_seen", 32'(popped), 32'(pushed));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 The module SHALL be clocked by a single clock and reset asynchronously, active-low.
REQ-002 Parameter WIDTH, default 8: data width; legal values are powers of two from 4 to 64.
REQ-003 Parameter SHIFT_W, default log2(WIDTH) = 3: shift-amount width, derived from WIDTH and not overridden.
REQ-004 clk  input  1: rising-edge clock.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 in_valid  input  1: qualifies data_in, shift, dir and mode in the current cycle.
REQ-007 data_in  input  WIDTH: operand.
REQ-008 shift  input  SHIFT_W: shift amount, 0 to WIDTH-1.
REQ-009 dir  input  1: 0 = left, 1 = right.
REQ-010 mode  input  2: 00 = logical, 01 = arithmetic, 10 = rotate, 11 = reserved (treated as logical).
REQ-011 data_out  output  WIDTH: registered result.
REQ-012 out_valid  output  1: data_out holds the result of the operation accepted one cycle earlier.

Function
REQ-013 Latency SHALL be exactly 1 cycle:
- operands sampled with in_valid=1 at edge N appear on data_out at edge N (registered), with out_valid=1 in the following cycle.
REQ-014 No backpressure: a new operation SHALL be accepted every cycle in_valid=1.
REQ-015 When in_valid=0, data_out SHALL hold its last value and out_valid SHALL deassert at the next edge.
REQ-016 Logical left: vacated LSBs SHALL be filled with 0 and bits shifted past the MSB discarded.
REQ-017 Logical right: vacated MSBs SHALL be filled with 0.
REQ-018 Arithmetic right: vacated MSBs SHALL be filled with data_in[WIDTH-1].
REQ-019 Arithmetic left SHALL be identical to logical left.
REQ-020 Rotate: bits leaving one end SHALL re-enter at the opposite end, in the direction given by dir.
REQ-021 shift=0 SHALL pass data_in unchanged, in every mode and direction.
REQ-022 The maximum shift (WIDTH-1) SHALL leave at most one original bit in shift modes; no wrap beyond WIDTH-1 is possible.
REQ-023 The shift network SHALL be logarithmic:
- SHIFT_W cascaded stages;
- stage k conditionally shifts by 2^k under control of shift[k];
- implementation is a mux network, not variable shift operators chained over loops of WIDTH.
REQ-024 The combinational path SHALL be input to register only; no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n=0, data_out SHALL be 0 and out_valid SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight result.
REQ-027 After rst_n deasserts, the first valid result SHALL appear one cycle after the first in_valid=1 edge.

Structure
REQ-028 Mode encodings (MODE_LOGICAL, MODE_ARITH, MODE_ROTATE) SHALL be localparams in a shared package, barrel_shifter_pkg.
REQ-029 One sub-module, barrel_shifter_stage, SHALL be used:
- parameters WIDTH and STAGE_SHIFT;
- inputs: data, enable, dir, fill bit, rotate flag;
- instantiated SHIFT_W times via generate.
REQ-030 Output and valid registers SHALL live in the top module only.

Verification
REQ-031 data_in=11110000, mode=00, dir=0, shift=1 / 3 -> data_out=11100000 / 10000000, one cycle after in_valid.
REQ-032 data_in=11110000, mode=00, dir=1, shift=4 / 7 -> 00001111 / 00000001; data_in=00011111, shift=2 -> 00000111.
REQ-033 Arithmetic right, data_in=10101010, shift=3 -> 11110101; data_in=01010101, shift=3 -> 00001010.
REQ-034 Rotate checks:
- data_in=11001100, dir=0, shift=1 -> 10011001;
- dir=1, shift=3 -> 10011001;
- shift=0 in any mode -> 11001100.
REQ-035 Back-to-back in_valid for 8 cycles -> 8 consecutive correct results with out_valid high.
REQ-036 Reset timing:
- rst_n pulsed low between clock edges -> data_out=0 and out_valid=0 immediately;
- result resumes one cycle after the next valid input.
